spiflash_cmd_seq: RTL

- Hardware sequencer for flash write/erase/status commands, so firmware does not bit-bang them.
- Masters the 32-bit config Wishbone port of the SPI memory-mapped flash controller:
  - reg 0 (adr[2]=0): mode/pin control.
  - reg 1 (adr[2]=1): 8-bit shift; write starts a 16-cycle transfer, read returns last RX byte.
- Per command: disables memory-mapped mode, frames CS, shifts bytes, polls flash busy, then restores memory-mapped mode.

---
 rtl/spiflash_cmd_seq.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/spiflash_cmd_seq.sv
// Sequences SPI flash write-enable/erase/program/status commands over the flash controller's
// config Wishbone port. Define SPIFLASH_POLL_TIMEOUT_EN to bound busy polling by POLL_MAX.
module spiflash_cmd_seq #(
  parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
  input  logic        wb_clk_i,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        done,
  output logic [7:0]  status,
  output logic        err,
  output logic [2:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WREN = 3'd1;
  localparam logic [2:0] S_CMD  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_POLL = 3'd4;
  localparam logic [2:0] S_ENA  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // Bus access descriptor: {we, adr[2:0], sel[3:0], dat[31:0]}
  localparam logic [39:0] ACC_CS_LO = {1'b1, 3'd0, 4'b1011, 32'h0000_0100};
  localparam logic [39:0] ACC_CS_HI = {1'b1, 3'd0, 4'b1011, 32'h0000_0120};
  localparam logic [39:0] ACC_ENA   = {1'b1, 3'd0, 4'b1000, 32'h8000_0000};
  localparam logic [39:0] ACC_RX    = {1'b0, 3'd4, 4'b0001, 32'h0000_0000};

  function automatic logic [39:0] acc_tx(input logic [7:0] b);
    return {1'b1, 3'd4, 4'b0001, 24'h0, b};
  endfunction

  logic [2:0]  state_q, step_q;
  logic [1:0]  op_q;
  logic [23:0] addr_q;
  logic [8:0]  cnt_q;
  logic [7:0]  byte_q, status_q, opcode;
  logic        have_byte_q;
  logic        acc_req, acc_last, acc_done;
  logic [39:0] acc;

  always_comb begin
    case (op_q)
      2'd0:    opcode = 8'h20;
      2'd1:    opcode = 8'h02;
      2'd2:    opcode = 8'h05;
      default: opcode = 8'hAB;
    endcase
  end

  // Access wanted in the current state/step; acc_last marks the final access of a state.
  always_comb begin
    acc_req  = 1'b1;
    acc_last = 1'b0;
    acc      = ACC_CS_HI;
    case (state_q)
      S_WREN: begin
        case (step_q)
          3'd0:    acc = ACC_CS_LO;
          3'd1:    acc = acc_tx(8'h06);
          default: acc_last = 1'b1;
        endcase
      end
      S_CMD: begin
        case (step_q)
          3'd0: acc = ACC_CS_LO;
          3'd1: begin
            acc      = acc_tx(opcode);
            acc_last = op_q[1];
          end
          3'd2: acc = acc_tx(addr_q[23:16]);
          3'd3: acc = acc_tx(addr_q[15:8]);
          default: begin
            acc      = acc_tx(addr_q[7:0]);
            acc_last = 1'b1;
          end
        endcase
      end
      S_DATA: begin
        if (op_q == 2'd1 && cnt_q != 9'd0) begin
          acc_req = have_byte_q;
          acc     = acc_tx(byte_q);
        end else if (op_q == 2'd2 && step_q == 3'd0) begin
          acc = acc_tx(8'h00);
        end else if (op_q == 2'd2 && step_q == 3'd1) begin
          acc = ACC_RX;
        end else begin
          acc_last = 1'b1;
        end
      end
      S_POLL: begin
        case (step_q)
          3'd0:    acc = ACC_CS_LO;
          3'd1:    acc = acc_tx(8'h05);
          3'd2:    acc = acc_tx(8'h00);
          3'd3:    acc = ACC_RX;
          default: acc_last = 1'b1;
        endcase
      end
      S_ENA: begin
        acc      = ACC_ENA;
        acc_last = 1'b1;
      end
      default: acc_req = 1'b0;
    endcase
  end

  assign acc_done  = m_cyc_o && m_ack_i;
  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign status    = status_q;
  assign wr_ready  = wr_valid && (state_q == S_DATA) && (op_q == 2'd1) && (cnt_q != 9'd0) &&
                     !have_byte_q;

`ifdef SPIFLASH_POLL_TIMEOUT_EN
  logic [23:0] poll_cnt_q;
  logic        err_q;
  logic        unused_dat;
  assign err        = err_q;
  assign unused_dat = ^m_dat_i[31:8];
`else
  logic unused_dat;
  assign err        = 1'b0;
  assign unused_dat = ^{m_dat_i[31:8], POLL_MAX};
`endif

  always_ff @(posedge wb_clk_i) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      op_q        <= 2'd0;
      addr_q      <= 24'd0;
      cnt_q       <= 9'd0;
      byte_q      <= 8'd0;
      have_byte_q <= 1'b0;
      status_q    <= 8'd0;
      m_cyc_o     <= 1'b0;
      m_stb_o     <= 1'b0;
      m_we_o      <= 1'b0;
      m_adr_o     <= 3'd0;
      m_dat_o     <= 32'd0;
      m_sel_o     <= 4'd0;
`ifdef SPIFLASH_POLL_TIMEOUT_EN
      poll_cnt_q  <= 24'd0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Dropping cyc on the ack edge guarantees one idle cycle before the next access.
      if (acc_done) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
        if (!m_we_o) status_q <= m_dat_i[7:0];
      end else if (!m_cyc_o && acc_req) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        {m_we_o, m_adr_o, m_sel_o, m_dat_o} <= acc;
      end

      if (wr_ready) begin
        byte_q      <= wr_data;
        have_byte_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            addr_q      <= cmd_addr;
            cnt_q       <= (cmd_len > 9'd256) ? 9'd256 : cmd_len;
            step_q      <= 3'd0;
            have_byte_q <= 1'b0;
            state_q     <= cmd_op[1] ? S_CMD : S_WREN;
`ifdef SPIFLASH_POLL_TIMEOUT_EN
            poll_cnt_q  <= 24'd0;
            err_q       <= 1'b0;
`endif
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          if (acc_done) begin
            if (state_q == S_DATA && op_q == 2'd1 && cnt_q != 9'd0) begin
              cnt_q       <= cnt_q - 9'd1;
              have_byte_q <= 1'b0;
            end else if (!acc_last) begin
              step_q <= step_q + 3'd1;
            end else begin
              step_q <= 3'd0;
              case (state_q)
                S_WREN: state_q <= S_CMD;
                S_CMD:  state_q <= S_DATA;
                S_DATA: state_q <= op_q[1] ? S_ENA : S_POLL;
                S_POLL: begin
                  if (!status_q[0]) begin
                    state_q <= S_ENA;
`ifdef SPIFLASH_POLL_TIMEOUT_EN
                  end else if (poll_cnt_q >= POLL_MAX - 24'd1) begin
                    err_q   <= 1'b1;
                    state_q <= S_ENA;
                  end else begin
                    poll_cnt_q <= poll_cnt_q + 24'd1;
`endif
                  end
                end
                default: state_q <= S_DONE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
